hist_agc_ctrl: RTL

HIST_AGC_CTRL -- requirements
Module: hist_agc_ctrl

---
 rtl/hist_agc_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hist_agc_ctrl.sv
// Histogram-driven AGC sweep controller: walks each histogram line, freezes and reads it, and nudges that line's gain toward TARGET_MAG.
// Optional feature macro HIST_AGC_SIG_BALANCE_EN adds SIG_TOL and the per-line dc_alarm output.
module hist_agc_ctrl #(
  parameter int unsigned LINES      = 1,
  parameter int unsigned GAIN_W     = 6,
  parameter int unsigned GAIN_INIT  = 32,
  parameter int unsigned TARGET_MAG = 21627,
  parameter int unsigned HYST       = 1024,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned PERIOD     = 65536
`ifdef HIST_AGC_SIG_BALANCE_EN
  , parameter int unsigned SIG_TOL  = 4096
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      hist_lock,
  output logic [7:0]                hist_addr,
  input  logic [31:0]               hist_result,
  output logic [LINES*GAIN_W-1:0]   gain,
  output logic                      busy,
  output logic                      done
`ifdef HIST_AGC_SIG_BALANCE_EN
  , output logic [LINES-1:0]        dc_alarm
`endif
);

  localparam int unsigned TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned LO_TH = (TARGET_MAG > HYST) ? TARGET_MAG - HYST : 0;
  localparam int unsigned HI_TH = (TARGET_MAG + HYST > 65535) ? 65535 : TARGET_MAG + HYST;

  localparam logic [16:0]       LO_17    = 17'(LO_TH);
  localparam logic [16:0]       HI_17    = 17'(HI_TH);
  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_INIT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(PERIOD - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [7:0]        IDX_LAST = 8'(LINES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_SEL     = 3'd2;
  localparam logic [2:0] ST_FREEZE  = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_UPDATE  = 3'd5;
  localparam logic [2:0] ST_RELEASE = 3'd6;

  logic [2:0]              state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [SET_W-1:0]        settle_q, settle_d;
  logic [7:0]              index_q, index_d;
  logic                    lock_q, lock_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             mag_q, mag_d;
  logic [LINES*GAIN_W-1:0] gain_q, gain_d;
  logic [16:0]             mag_ext;
  logic                    gain_up, gain_dn;
  logic [GAIN_W-1:0]       cur_gain;

  assign mag_ext = {1'b0, mag_q};
  assign gain_up = (mag_ext < LO_17);
  assign gain_dn = (mag_ext > HI_17);

`ifdef HIST_AGC_SIG_BALANCE_EN
  logic [15:0]      sig_q, sig_d;
  logic [LINES-1:0] alarm_q, alarm_d;
  logic [16:0]      sig_dist;
  logic             sig_off;

  assign sig_dist = sig_q[15] ? (17'(sig_q) - 17'd32768) : (17'd32768 - 17'(sig_q));
  assign sig_off  = (sig_dist > 17'(SIG_TOL));
  assign dc_alarm = alarm_q;
`else
  logic unused_sig_bits;
  assign unused_sig_bits = ^hist_result[31:16];
`endif

  // Sweep sequencing; dropping enable wins over every transition.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    settle_d = settle_q;
    index_d  = index_q;
    mag_d    = mag_q;
    gain_d   = gain_q;
    cur_gain = '0;
`ifdef HIST_AGC_SIG_BALANCE_EN
    sig_d    = sig_q;
    alarm_d  = alarm_q;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
        ST_WAIT: begin
          if (timer_q == TMR_LAST) begin
            state_d  = ST_SEL;
            index_d  = '0;
            settle_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        ST_SEL, ST_FREEZE: begin
          if (settle_q == SET_LAST) begin
            state_d  = (state_q == ST_SEL) ? ST_FREEZE : ST_CAPTURE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        ST_CAPTURE: begin
          mag_d   = hist_result[15:0];
`ifdef HIST_AGC_SIG_BALANCE_EN
          sig_d   = hist_result[31:16];
`endif
          state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          for (int i = 0; i < int'(LINES); i++) begin
            if (index_q == 8'(i)) begin
              cur_gain = gain_q[i*GAIN_W +: GAIN_W];
              if (gain_up && (cur_gain != GAIN_MAX)) begin
                gain_d[i*GAIN_W +: GAIN_W] = cur_gain + GAIN_W'(1);
              end else if (gain_dn && (cur_gain != '0)) begin
                gain_d[i*GAIN_W +: GAIN_W] = cur_gain - GAIN_W'(1);
              end
`ifdef HIST_AGC_SIG_BALANCE_EN
              alarm_d[i] = sig_off;
`endif
            end
          end
          if (index_q == IDX_LAST) begin
            state_d = ST_RELEASE;
          end else begin
            index_d  = index_q + 8'd1;
            settle_d = '0;
            state_d  = ST_SEL;
          end
        end
        ST_RELEASE: begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    lock_d = (state_d == ST_FREEZE) || (state_d == ST_CAPTURE) || (state_d == ST_UPDATE);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_WAIT);
    done_d = (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      settle_q <= '0;
      index_q  <= '0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mag_q    <= '0;
      gain_q   <= {LINES{GAIN_RST}};
`ifdef HIST_AGC_SIG_BALANCE_EN
      sig_q    <= '0;
      alarm_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      index_q  <= index_d;
      lock_q   <= lock_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mag_q    <= mag_d;
      gain_q   <= gain_d;
`ifdef HIST_AGC_SIG_BALANCE_EN
      sig_q    <= sig_d;
      alarm_q  <= alarm_d;
`endif
    end
  end

  assign hist_lock = lock_q;
  assign hist_addr = index_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign gain      = gain_q;

endmodule
